// File: rtl/apb_cmd_master_if.sv
// Command, response and APB bus bundle for apb_cmd_master.
// master = the initiator block, slave = the requester plus APB peripheral side.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 40
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_vld, cmd_write, cmd_addr, cmd_wdata, rsp_rdy, prdata, pready, pslverr,
    output cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_timeout, busy,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_vld, cmd_write, cmd_addr, cmd_wdata, rsp_rdy, prdata, pready, pslverr,
    input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_timeout, busy,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Command-driven APB initiator: FIFO-buffered commands issued as SETUP/ACCESS transfers.
// Command to psel in 2 edges, one transfer per 3 cycles; cmd_rdy drops when the FIFO is full.
module apb_cmd_master #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 40
) (
  input logic              pclk,
  input logic              presetn,
  apb_cmd_master_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  cmd_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [31:0]       r_pwdata;
  logic              r_rsp_vld;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  cmd_t w_cmd_in;
  cmd_t w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_cmd_in = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  assign w_head   = r_mem[r_rd_ptr];
  assign w_full   = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // full blocks a push even when a pop frees a slot in the same cycle
  assign w_push   = bus.cmd_vld & ~w_full;
  assign w_pop    = ~w_empty & ((r_state == S_IDLE) |
                                ((r_state == S_RESP) & bus.rsp_rdy));

  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_paddr       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_vld     <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_paddr   <= w_head.addr;
            r_pwrite  <= w_head.write;
            r_pwdata  <= w_head.wdata;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready takes priority over a timeout firing in the same cycle
          if (bus.pready) begin
            r_rsp_rdata   <= r_pwrite ? 32'h0 : bus.prdata;
            r_rsp_err     <= bus.pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_vld     <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (TO_EN && (r_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
              r_rsp_rdata   <= 32'h0;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_rsp_vld     <= 1'b1;
              r_psel        <= 1'b0;
              r_penable     <= 1'b0;
              r_state       <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.rsp_rdy) begin
            r_rsp_vld <= 1'b0;
            if (!w_empty) begin
              r_paddr   <= w_head.addr;
              r_pwrite  <= w_head.write;
              r_pwdata  <= w_head.wdata;
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_state   <= S_SETUP;
            end else begin
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy     = ~w_full;
  assign bus.busy        = ~w_empty | (r_state != S_IDLE);
  assign bus.paddr       = r_paddr;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_vld     = r_rsp_vld;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with FIFO_DEPTH=4, TIMEOUT_CYC=8.
module tb_apb_cmd_master;
  logic pclk;
  logic presetn;
  int   vecs;
  int   errs;

  apb_cmd_master_if #(.ADDR_W(40)) u_if ();

  apb_cmd_master #(
    .FIFO_DEPTH (4),
    .TIMEOUT_CYC(8),
    .ADDR_W     (40)
  ) u_dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (u_if)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [39:0] a, input logic [31:0] d);
    u_if.cmd_write = w;
    u_if.cmd_addr  = a;
    u_if.cmd_wdata = d;
    u_if.cmd_vld   = 1'b1;
    tick();
    u_if.cmd_vld   = 1'b0;
  endtask

  task automatic accept_rsp();
    u_if.rsp_rdy = 1'b1;
    tick();
    u_if.rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    presetn        = 1'b0;
    u_if.cmd_vld   = 1'b0;
    u_if.cmd_write = 1'b0;
    u_if.cmd_addr  = '0;
    u_if.cmd_wdata = '0;
    u_if.rsp_rdy   = 1'b0;
    u_if.prdata    = '0;
    u_if.pready    = 1'b1;
    u_if.pslverr   = 1'b0;
    tick();
    vecs++;
    if ({u_if.psel, u_if.penable, u_if.pwrite, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout, u_if.busy} !== 7'b0) begin
      errs++; $display("FAIL rst_ctrl got %b exp 0000000", {u_if.psel, u_if.penable, u_if.pwrite, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout, u_if.busy});
    end
    vecs++;
    if ({u_if.paddr, u_if.pwdata, u_if.rsp_rdata} !== 104'h0) begin
      errs++; $display("FAIL rst_data got %h exp 0", {u_if.paddr, u_if.pwdata, u_if.rsp_rdata});
    end
    presetn = 1'b1;
    tick();
    vecs++;
    if (u_if.cmd_rdy !== 1'b1) begin errs++; $display("FAIL rst_cmd_rdy got %b exp 1", u_if.cmd_rdy); end
  endtask

  task automatic test_single_write();
    u_if.pready = 1'b1;
    issue(1'b1, 40'h00_1001_5000, 32'hA5A5_0001);
    vecs++;
    if ({u_if.psel, u_if.busy} !== 2'b01) begin errs++; $display("FAIL wr_e0 psel,busy got %b exp 01", {u_if.psel, u_if.busy}); end
    tick();
    vecs++;
    if ({u_if.psel, u_if.penable, u_if.pwrite} !== 3'b101) begin errs++; $display("FAIL wr_setup got %b exp 101", {u_if.psel, u_if.penable, u_if.pwrite}); end
    vecs++;
    if ({u_if.paddr, u_if.pwdata} !== {40'h00_1001_5000, 32'hA5A5_0001}) begin
      errs++; $display("FAIL wr_addr_data got %h exp %h", {u_if.paddr, u_if.pwdata}, {40'h00_1001_5000, 32'hA5A5_0001});
    end
    tick();
    vecs++;
    if ({u_if.psel, u_if.penable, u_if.rsp_vld} !== 3'b110) begin errs++; $display("FAIL wr_access got %b exp 110", {u_if.psel, u_if.penable, u_if.rsp_vld}); end
    tick();
    vecs++;
    if ({u_if.psel, u_if.penable, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout} !== 5'b00100) begin
      errs++; $display("FAIL wr_rsp got %b exp 00100", {u_if.psel, u_if.penable, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout});
    end
    vecs++;
    if (u_if.rsp_rdata !== 32'h0) begin errs++; $display("FAIL wr_rdata got %h exp 0", u_if.rsp_rdata); end
    accept_rsp();
    vecs++;
    if ({u_if.rsp_vld, u_if.busy} !== 2'b00) begin errs++; $display("FAIL wr_done got %b exp 00", {u_if.rsp_vld, u_if.busy}); end
  endtask

  task automatic test_read_wait();
    u_if.prdata = 32'h1234_5678;
    u_if.pready = 1'b0;
    issue(1'b0, 40'h00_1001_6004, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if ({u_if.psel, u_if.penable, u_if.paddr} !== {2'b11, 40'h00_1001_6004}) begin
        errs++; $display("FAIL rd_wait%0d got %h exp %h", i, {u_if.psel, u_if.penable, u_if.paddr}, {2'b11, 40'h00_1001_6004});
      end
      u_if.pready = (i == 3);
      tick();
    end
    vecs++;
    if ({u_if.psel, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout} !== 4'b0100) begin
      errs++; $display("FAIL rd_rsp got %b exp 0100", {u_if.psel, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout});
    end
    vecs++;
    if (u_if.rsp_rdata !== 32'h1234_5678) begin errs++; $display("FAIL rd_rdata got %h exp 12345678", u_if.rsp_rdata); end
    accept_rsp();
  endtask

  task automatic test_pslverr();
    u_if.pready  = 1'b1;
    u_if.pslverr = 1'b1;
    u_if.prdata  = 32'hDEAD_0001;
    issue(1'b0, 40'h00_1001_7000, 32'h0);
    tick();
    tick();
    tick();
    vecs++;
    if ({u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout} !== 3'b110) begin
      errs++; $display("FAIL slverr_flags got %b exp 110", {u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout});
    end
    vecs++;
    if (u_if.rsp_rdata !== 32'hDEAD_0001) begin errs++; $display("FAIL slverr_rdata got %h exp dead0001", u_if.rsp_rdata); end
    u_if.pslverr = 1'b0;
    accept_rsp();
  endtask

  task automatic test_timeout(input logic late_ready);
    u_if.pready = 1'b0;
    u_if.prdata = 32'hFFFF_0000;
    issue(1'b0, 40'h00_1002_0000, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if ({u_if.psel, u_if.penable, u_if.rsp_vld} !== 3'b110) begin
        errs++; $display("FAIL to_access%0d got %b exp 110", i, {u_if.psel, u_if.penable, u_if.rsp_vld});
      end
      if (i == 7) u_if.pready = late_ready;
      tick();
    end
    vecs++;
    if ({u_if.psel, u_if.penable, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout} !== (late_ready ? 5'b00100 : 5'b00111)) begin
      errs++; $display("FAIL to_end_flags late=%0d got %b exp %b", late_ready,
                       {u_if.psel, u_if.penable, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_timeout}, (late_ready ? 5'b00100 : 5'b00111));
    end
    vecs++;
    if (u_if.rsp_rdata !== (late_ready ? 32'hFFFF_0000 : 32'h0)) begin
      errs++; $display("FAIL to_rdata late=%0d got %h exp %h", late_ready, u_if.rsp_rdata, (late_ready ? 32'hFFFF_0000 : 32'h0));
    end
    u_if.pready = 1'b1;
    accept_rsp();
  endtask

  task automatic test_back_to_back();
    logic [39:0] addr [5];
    for (int k = 0; k < 5; k++) addr[k] = 40'h00_3000_0000 + 40'(k * 16);
    u_if.pready = 1'b1;
    u_if.prdata = 32'hC0DE_0000;
    u_if.rsp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      u_if.cmd_write = 1'b0;
      u_if.cmd_addr  = addr[k];
      u_if.cmd_vld   = 1'b1;
      vecs++;
      if (u_if.cmd_rdy !== 1'b1) begin errs++; $display("FAIL bp_push%0d cmd_rdy got %b exp 1", k, u_if.cmd_rdy); end
      tick();
    end
    u_if.cmd_addr = 40'h00_3000_0FF0;
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if ({u_if.cmd_rdy, u_if.psel, u_if.rsp_vld, u_if.busy} !== 4'b0011) begin
        errs++; $display("FAIL bp_stall%0d rdy,psel,vld,busy got %b exp 0011", k, {u_if.cmd_rdy, u_if.psel, u_if.rsp_vld, u_if.busy});
      end
      tick();
    end
    u_if.cmd_vld = 1'b0;
    vecs++;
    if ({u_if.paddr, u_if.rsp_rdata} !== {addr[0], 32'hC0DE_0000}) begin
      errs++; $display("FAIL bp_first got %h exp %h", {u_if.paddr, u_if.rsp_rdata}, {addr[0], 32'hC0DE_0000});
    end
    u_if.rsp_rdy = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      vecs++;
      if ({u_if.cmd_rdy, u_if.psel, u_if.penable, u_if.rsp_vld, u_if.paddr} !== {4'b1100, addr[k]}) begin
        errs++; $display("FAIL bp_setup%0d got %h exp %h", k, {u_if.cmd_rdy, u_if.psel, u_if.penable, u_if.rsp_vld, u_if.paddr}, {4'b1100, addr[k]});
      end
      tick();
      tick();
      vecs++;
      if ({u_if.psel, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_rdata} !== {3'b010, 32'hC0DE_0000}) begin
        errs++; $display("FAIL bp_rsp%0d got %h exp %h", k, {u_if.psel, u_if.rsp_vld, u_if.rsp_err, u_if.rsp_rdata}, {3'b010, 32'hC0DE_0000});
      end
    end
    tick();
    u_if.rsp_rdy = 1'b0;
    vecs++;
    if ({u_if.rsp_vld, u_if.psel, u_if.busy} !== 3'b000) begin
      errs++; $display("FAIL bp_drain got %b exp 000", {u_if.rsp_vld, u_if.psel, u_if.busy});
    end
  endtask

  task automatic test_reset_mid();
    u_if.pready = 1'b0;
    issue(1'b0, 40'h00_1003_0000, 32'h0);
    issue(1'b1, 40'h00_1003_0004, 32'h5555_AAAA);
    tick();
    vecs++;
    if ({u_if.psel, u_if.penable} !== 2'b11) begin errs++; $display("FAIL rm_access got %b exp 11", {u_if.psel, u_if.penable}); end
    #2;
    presetn = 1'b0;
    #1;
    vecs++;
    if ({u_if.psel, u_if.penable, u_if.busy} !== 3'b000) begin
      errs++; $display("FAIL rm_async got %b exp 000", {u_if.psel, u_if.penable, u_if.busy});
    end
    tick();
    tick();
    presetn     = 1'b1;
    u_if.pready = 1'b1;
    tick();
    vecs++;
    if ({u_if.busy, u_if.cmd_rdy} !== 2'b01) begin errs++; $display("FAIL rm_release busy,rdy got %b exp 01", {u_if.busy, u_if.cmd_rdy}); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++;
      if ({u_if.rsp_vld, u_if.psel} !== 2'b00) begin
        errs++; $display("FAIL rm_quiet%0d vld,psel got %b exp 00", k, {u_if.rsp_vld, u_if.psel});
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_pslverr();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
